// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: definitions shared by the UART receiver control slice.
//   state_t          - controller FSM state encoding (IDLE..DONE)
//   MIN_PRESCALE     - smallest oversampling ratio the receiver runs at
//   CHK_OFFSET       - checkers evaluate CHK_OFFSET ticks after mid-bit
//   clamp_prescale() - effective prescale, max(pres, min_p)
//   chk_tick()       - tick index at which the bit checkers evaluate
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int MIN_PRESCALE = 8;
    localparam int CHK_OFFSET   = 2;

    function automatic logic [7:0] clamp_prescale(input logic [7:0] pres,
                                                  input logic [7:0] min_p);
        return (pres < min_p) ? min_p : pres;
    endfunction

    // With P >= 8 this is always at most P-2, so a checker verdict is
    // settled before the controller reads it on the last tick.
    function automatic logic [7:0] chk_tick(input logic [7:0] p);
        return (p >> 1) + 8'(CHK_OFFSET);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// uart_rx_edge_bit_cnt: oversampling tick counter and frame bit counter.
//   CLK, RST  - clock, asynchronous active-low reset
//   clr       - force both counters to 0 (wins over run)
//   run       - advance the tick counter this cycle
//   lt        - last tick index of a bit (P-1)
//   edge_cnt  - tick index within the current bit
//   bit_cnt   - bit index within the frame
//   at_lt     - running and on the last tick of the current bit
module uart_rx_edge_bit_cnt (
    input  logic       CLK,
    input  logic       RST,
    input  logic       clr,
    input  logic       run,
    input  logic [7:0] lt,
    output logic [7:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       at_lt
);

    assign at_lt = run && (edge_cnt == lt);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (run) begin
            if (edge_cnt == lt) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencing controller of the UART receiver.
// Walks each frame through start, data, optional parity and stop bits,
// drives the checker/sampler enables and reports the frame verdict.
//   CLK, RST                 - oversampling clock, async active-low reset
//   Rx_In                    - serial line (idle high); only watched in IDLE/DONE
//   Prescale                 - oversampling ratio, clamped to MIN_PRESCALE
//   Par_En                   - parity bit present, latched at frame start
//   Strt_Glitch/Par_Err/Stp_Err - checker verdicts, read on a bit's last tick
//   Edge_Cnt, Bit_Cnt        - tick within bit, bit within frame
//   *_En                     - level enables for sampler and checkers
//   Data_Valid/Parity_Error/Frame_Error - one-cycle verdict pulses in DONE
//   Busy                     - controller not idle
module uart_rx_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int MIN_PRESCALE = uart_rx_pkg::MIN_PRESCALE
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Rx_In,
    input  logic [7:0] Prescale,
    input  logic       Par_En,
    input  logic       Strt_Glitch,
    input  logic       Par_Err,
    input  logic       Stp_Err,
    output logic [7:0] Edge_Cnt,
    output logic [3:0] Bit_Cnt,
    output logic       Dat_Samp_En,
    output logic       Strt_Chk_En,
    output logic       Deser_En,
    output logic       Par_Chk_En,
    output logic       Stp_Chk_En,
    output logic       Data_Valid,
    output logic       Parity_Error,
    output logic       Frame_Error,
    output logic       Busy
);

    import uart_rx_pkg::*;

    localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

    state_t     state, state_nx;
    logic       par_en_q, par_en_nx;
    logic       par_flag, par_flag_nx;
    logic       dv_nx, pe_nx, fe_nx;
    logic [7:0] p_eff, lt;
    logic       run, clr, at_lt;

    assign p_eff = clamp_prescale(Prescale, 8'(MIN_PRESCALE));
    assign lt    = p_eff - 8'd1;

    // Counters only run inside a frame; they are zeroed whenever the frame
    // ends (DONE) or aborts (IDLE), so the next START always begins at 0.
    assign run = (state == START) || (state == DATA) ||
                 (state == PARITY) || (state == STOP);
    assign clr = !run || (state_nx == IDLE) || (state_nx == DONE);

    uart_rx_edge_bit_cnt u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (clr),
        .run      (run),
        .lt       (lt),
        .edge_cnt (Edge_Cnt),
        .bit_cnt  (Bit_Cnt),
        .at_lt    (at_lt)
    );

    always_comb begin
        state_nx    = state;
        par_en_nx   = par_en_q;
        par_flag_nx = par_flag;
        dv_nx       = 1'b0;
        pe_nx       = 1'b0;
        fe_nx       = 1'b0;
        case (state)
            IDLE: begin
                if (!Rx_In) begin
                    state_nx    = START;
                    par_en_nx   = Par_En;
                    par_flag_nx = 1'b0;
                end
            end
            START: begin
                if (at_lt) state_nx = Strt_Glitch ? IDLE : DATA;
            end
            DATA: begin
                if (at_lt && (Bit_Cnt == LAST_DATA))
                    state_nx = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (at_lt) begin
                    state_nx    = STOP;
                    par_flag_nx = Par_Err;
                end
            end
            STOP: begin
                // Verdict pulses are computed here and registered so they
                // appear for exactly the single DONE cycle.
                if (at_lt) begin
                    state_nx = DONE;
                    dv_nx    = !par_flag && !Stp_Err;
                    pe_nx    = par_flag;
                    fe_nx    = Stp_Err;
                end
            end
            DONE: begin
                if (!Rx_In) begin
                    state_nx    = START;
                    par_en_nx   = Par_En;
                    par_flag_nx = 1'b0;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Enables decode the next state and are registered alongside it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            par_en_q     <= 1'b0;
            par_flag     <= 1'b0;
            Dat_Samp_En  <= 1'b0;
            Strt_Chk_En  <= 1'b0;
            Deser_En     <= 1'b0;
            Par_Chk_En   <= 1'b0;
            Stp_Chk_En   <= 1'b0;
            Data_Valid   <= 1'b0;
            Parity_Error <= 1'b0;
            Frame_Error  <= 1'b0;
            Busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            par_en_q     <= par_en_nx;
            par_flag     <= par_flag_nx;
            Dat_Samp_En  <= (state_nx == START) || (state_nx == DATA) ||
                            (state_nx == PARITY) || (state_nx == STOP);
            Strt_Chk_En  <= (state_nx == START);
            Deser_En     <= (state_nx == DATA);
            Par_Chk_En   <= (state_nx == PARITY);
            Stp_Chk_En   <= (state_nx == STOP);
            Data_Valid   <= dv_nx;
            Parity_Error <= pe_nx;
            Frame_Error  <= fe_nx;
            Busy         <= (state_nx != IDLE);
        end
    end

endmodule
